// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the MIPS32 pipeline.
// Consumes EX/MEM fields, performs aligned word loads/stores against an internal
// synchronous-write, registered-read data memory and drives the MEM/WB register.
// Loads take two cycles; stall is raised during the second one.
//
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   ex_valid          EX/MEM entry valid
//   ex_opcode         operation code
//   ex_alu_out        ALU result; byte address for LW/SW
//   ex_store_data     store data for SW
//   ex_dest_reg       destination register
//   ex_is_r           R-type flag, passed through
//   stall             upstream must hold ex_* while high
//   wb_valid          MEM/WB entry valid
//   wb_opcode         registered opcode
//   wb_result         load data or passed-through ALU result
//   wb_dest_reg       registered destination register
//   wb_is_r           registered R-type flag
//   wb_reg_write      writeback enable
//   misalign_err      one-cycle pulse on a misaligned LW/SW
module mem_stage #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter logic [5:0]  OP_LW  = 6'd14,
  parameter logic [5:0]  OP_SW  = 6'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [5:0]  ex_opcode,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_dest_reg,
  input  logic        ex_is_r,
  output logic        stall,
  output logic        wb_valid,
  output logic [5:0]  wb_opcode,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_dest_reg,
  output logic        wb_is_r,
  output logic        wb_reg_write,
  output logic        misalign_err
);

  typedef enum logic [0:0] {StRun, StLoadWait} state_e;

  state_e      state_q, state_d;
  logic        wb_valid_q, wb_valid_d;
  logic [5:0]  wb_opcode_q, wb_opcode_d;
  logic [31:0] wb_result_q, wb_result_d;
  logic [4:0]  wb_dest_reg_q, wb_dest_reg_d;
  logic        wb_is_r_q, wb_is_r_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        misalign_q, misalign_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;

  logic [ADDR_W-1:0] idx;
  logic              aligned, is_mem_op, accept, mem_rd_en, mem_wr_en;

  // Address bits above the word index are ignored (addresses wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^ex_alu_out[31:ADDR_W+2];

  function automatic logic writes_reg(input logic [5:0] op);
    return (op <= 6'd5) || ((op >= 6'd8) && (op <= 6'd12)) || (op == OP_LW);
  endfunction

  always_comb begin
    idx       = ex_alu_out[ADDR_W+1:2];
    aligned   = (ex_alu_out[1:0] == 2'b00);
    is_mem_op = (ex_opcode == OP_LW) || (ex_opcode == OP_SW);
    // Inputs are only consumed in RUN; LOAD_WAIT ignores the held upstream entry.
    accept    = ex_valid && (state_q == StRun);
    mem_rd_en = accept && aligned && (ex_opcode == OP_LW);
    mem_wr_en = accept && aligned && (ex_opcode == OP_SW) && !rst;
  end

  always_comb begin
    state_d        = state_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    misalign_d     = 1'b0;
    wb_opcode_d    = wb_opcode_q;
    wb_result_d    = wb_result_q;
    wb_dest_reg_d  = wb_dest_reg_q;
    wb_is_r_d      = wb_is_r_q;
    case (state_q)
      StRun: begin
        if (ex_valid) begin
          if (is_mem_op && !aligned) begin
            misalign_d = 1'b1;
          end else begin
            // Tag fields are captured at issue, so a load only adds its data later.
            wb_opcode_d   = ex_opcode;
            wb_dest_reg_d = ex_dest_reg;
            wb_is_r_d     = ex_is_r;
            if (ex_opcode == OP_LW) begin
              state_d = StLoadWait;
            end else begin
              wb_valid_d     = 1'b1;
              wb_result_d    = ex_alu_out;
              wb_reg_write_d = writes_reg(ex_opcode) && (ex_dest_reg != 5'd0);
            end
          end
        end
      end
      StLoadWait: begin
        state_d        = StRun;
        wb_valid_d     = 1'b1;
        wb_result_d    = rd_data_q;
        wb_reg_write_d = writes_reg(wb_opcode_q) && (wb_dest_reg_q != 5'd0);
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      wb_valid_q     <= 1'b0;
      wb_opcode_q    <= 6'd0;
      wb_result_q    <= 32'd0;
      wb_dest_reg_q  <= 5'd0;
      wb_is_r_q      <= 1'b0;
      wb_reg_write_q <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wb_valid_q     <= wb_valid_d;
      wb_opcode_q    <= wb_opcode_d;
      wb_result_q    <= wb_result_d;
      wb_dest_reg_q  <= wb_dest_reg_d;
      wb_is_r_q      <= wb_is_r_d;
      wb_reg_write_q <= wb_reg_write_d;
      misalign_q     <= misalign_d;
    end
  end

  // Data memory: not reset. A store and a load never share an edge, so a load
  // issued right after a store always sees the stored word.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[idx] <= ex_store_data;
    end
    if (mem_rd_en) begin
      rd_data_q <= mem[idx];
    end
  end

  assign stall        = (state_q == StLoadWait);
  assign wb_valid     = wb_valid_q;
  assign wb_opcode    = wb_opcode_q;
  assign wb_result    = wb_result_q;
  assign wb_dest_reg  = wb_dest_reg_q;
  assign wb_is_r      = wb_is_r_q;
  assign wb_reg_write = wb_reg_write_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed test-plan steps followed by randomized
// operations checked against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest_reg;
  logic        ex_is_r;
  logic        stall;
  logic        wb_valid;
  logic [5:0]  wb_opcode;
  logic [31:0] wb_result;
  logic [4:0]  wb_dest_reg;
  logic        wb_is_r;
  logic        wb_reg_write;
  logic        misalign_err;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .ex_dest_reg   (ex_dest_reg),
    .ex_is_r       (ex_is_r),
    .stall         (stall),
    .wb_valid      (wb_valid),
    .wb_opcode     (wb_opcode),
    .wb_result     (wb_result),
    .wb_dest_reg   (wb_dest_reg),
    .wb_is_r       (wb_is_r),
    .wb_reg_write  (wb_reg_write),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: word memory and the last completed writeback result.
  logic [31:0] mdl_mem [256];
  bit          mdl_wr  [256];
  logic [31:0] exp_result;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic bit mdl_writes(input logic [5:0] op);
    return (op <= 6'd5) || (op >= 6'd8 && op <= 6'd12) || (op == 6'd14);
  endfunction

  // Drive one EX/MEM entry, advance through its full latency and check outputs.
  task automatic step(input bit v, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] dest, input bit isr);
    int idx;
    bit memop;
    ex_valid      = v;
    ex_opcode     = op;
    ex_alu_out    = addr;
    ex_store_data = data;
    ex_dest_reg   = dest;
    ex_is_r       = isr;
    idx   = int'((addr >> 2) % 256);
    memop = (op == 6'd14) || (op == 6'd15);
    @(posedge clk);
    #1;
    if (!v) begin
      chk("idle_valid", 32'(wb_valid), 32'd0);
      chk("idle_regwr", 32'(wb_reg_write), 32'd0);
      chk("idle_result_hold", wb_result, exp_result);
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_misalign", 32'(misalign_err), 32'd0);
    end else if (memop && addr[1:0] != 2'b00) begin
      chk("mis_err", 32'(misalign_err), 32'd1);
      chk("mis_valid", 32'(wb_valid), 32'd0);
      chk("mis_stall", 32'(stall), 32'd0);
    end else if (op == 6'd14) begin
      chk("lw_stall", 32'(stall), 32'd1);
      chk("lw_valid_first", 32'(wb_valid), 32'd0);
      @(posedge clk);
      #1;
      exp_result = mdl_mem[idx];
      chk("lw_valid", 32'(wb_valid), 32'd1);
      chk("lw_result", wb_result, exp_result);
      chk("lw_regwr", 32'(wb_reg_write), 32'(dest != 5'd0));
      chk("lw_dest", 32'(wb_dest_reg), 32'(dest));
      chk("lw_opcode", 32'(wb_opcode), 32'(op));
      chk("lw_is_r", 32'(wb_is_r), 32'(isr));
      chk("lw_stall_after", 32'(stall), 32'd0);
      chk("lw_misalign", 32'(misalign_err), 32'd0);
    end else begin
      if (op == 6'd15) begin
        mdl_mem[idx] = data;
        mdl_wr[idx]  = 1'b1;
      end
      exp_result = addr;
      chk("op_valid", 32'(wb_valid), 32'd1);
      chk("op_result", wb_result, exp_result);
      chk("op_regwr", 32'(wb_reg_write), 32'(mdl_writes(op) && dest != 5'd0));
      chk("op_opcode", 32'(wb_opcode), 32'(op));
      chk("op_dest", 32'(wb_dest_reg), 32'(dest));
      chk("op_is_r", 32'(wb_is_r), 32'(isr));
      chk("op_stall", 32'(stall), 32'd0);
      chk("op_misalign", 32'(misalign_err), 32'd0);
    end
    ex_valid = 1'b0;
  endtask

  initial begin
    int          r, idx;
    logic [31:0] addr;
    logic [5:0]  op;
    for (int i = 0; i < 256; i++) begin
      mdl_mem[i] = 32'd0;
      mdl_wr[i]  = 1'b0;
    end
    rst = 1'b1;
    ex_valid = 1'b0; ex_opcode = 6'd0; ex_alu_out = 32'd0;
    ex_store_data = 32'd0; ex_dest_reg = 5'd0; ex_is_r = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_result = 32'd0;
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_result", wb_result, 32'd0);
    chk("rst_regwr", 32'(wb_reg_write), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_opcode", 32'(wb_opcode), 32'd0);
    rst = 1'b0;

    // Directed steps.
    step(1, 6'd0, 32'h0000_0007, 32'd0, 5'd5, 1'b1);      // ADD
    step(0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    step(1, 6'd15, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0);    // SW
    step(1, 6'd14, 32'h10, 32'd0, 5'd3, 1'b0);            // LW same index
    step(1, 6'd15, 32'h0000_0404, 32'h1234, 5'd0, 1'b0);  // wrapped SW
    step(1, 6'd14, 32'h4, 32'd0, 5'd7, 1'b0);
    step(1, 6'd14, 32'h11, 32'd0, 5'd3, 1'b0);            // misaligned LW
    step(1, 6'd15, 32'h12, 32'hFFFF_0000, 5'd0, 1'b0);    // misaligned SW
    step(1, 6'd14, 32'h10, 32'd0, 5'd3, 1'b0);            // memory unchanged
    step(1, 6'd8, 32'h55, 32'd0, 5'd0, 1'b0);             // ADDI to r0
    step(1, 6'd40, 32'h77, 32'd0, 5'd9, 1'b1);            // unknown opcode
    step(1, 6'd14, 32'h10, 32'd0, 5'd0, 1'b0);            // LW to r0

    // Reset during LOAD_WAIT aborts the load.
    ex_valid = 1'b1; ex_opcode = 6'd14; ex_alu_out = 32'h10; ex_dest_reg = 5'd4;
    @(posedge clk);
    #1;
    chk("abort_stall_pre", 32'(stall), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_valid = 1'b0;
    exp_result = 32'd0;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_valid", 32'(wb_valid), 32'd0);
    chk("abort_regwr", 32'(wb_reg_write), 32'd0);
    step(0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    step(1, 6'd0, 32'h0000_0009, 32'd0, 5'd6, 1'b1);

    // Randomized operations over a small index window so loads hit stores.
    for (int n = 0; n < 300; n++) begin
      r   = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 15));
      addr = ($urandom() & 32'hFFFF_FC00) | (32'(idx) << 2);
      if (r == 0) begin
        step(0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      end else if (r <= 2 || (r <= 4 && !mdl_wr[idx])) begin
        step(1, 6'd15, addr, $urandom(), 5'($urandom()), 1'($urandom()));
      end else if (r <= 4) begin
        step(1, 6'd14, addr, $urandom(), 5'($urandom()), 1'($urandom()));
      end else if (r == 5) begin
        addr = addr | 32'($urandom_range(1, 3));
        step(1, ($urandom_range(0, 1) == 0) ? 6'd14 : 6'd15, addr, $urandom(),
             5'($urandom()), 1'($urandom()));
      end else begin
        op = 6'($urandom());
        if (op == 6'd14 || op == 6'd15) op = 6'd3;
        step(1, op, $urandom(), $urandom(), 5'($urandom_range(0, 3)), 1'($urandom()));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
